// File: rtl/mmcm_drp_controller.sv
// rtl/mmcm_drp_controller.sv - MMCM DRP masked read-modify-write reconfiguration controller
// Holds the MMCM in reset across a batch of DRP writes, then releases it and qualifies LOCKED.
module mmcm_drp_controller #(
  parameter int DRDY_TIMEOUT_CYCLES = 64,
  parameter int RST_HOLD_CYCLES     = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [6:0]  i_req_addr,
  input  logic [15:0] i_req_mask,
  input  logic [15:0] i_req_data,
  input  logic        i_req_last,
  output logic        o_rsp_valid,
  output logic [1:0]  o_rsp_error,
  output logic [15:0] o_rsp_rdata,
  output logic        o_drp_den,
  output logic        o_drp_dwe,
  output logic [6:0]  o_drp_daddr,
  output logic [15:0] o_drp_di,
  input  logic [15:0] i_drp_do,
  input  logic        i_drp_drdy,
  output logic        o_mmcm_rst,
  input  logic        i_mmcm_locked,
  output logic        o_locked,
  output logic        o_busy
);

  localparam int MAX_AB = (DRDY_TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? DRDY_TIMEOUT_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_CNT = (LOCK_TIMEOUT_CYCLES > MAX_AB) ? LOCK_TIMEOUT_CYCLES : MAX_AB;
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DRDY_LIM = CW'(DRDY_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_HOLD, S_LOCK_WAIT, S_RSP
  } state_t;

  state_t         state_q;
  logic [6:0]     addr_q;
  logic [15:0]    mask_q;
  logic [15:0]    data_q;
  logic [15:0]    old_q;
  logic           last_q;
  logic           rst_held_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     err_q;
  logic           sync1_q;
  logic           sync2_q;
  logic           den_q;
  logic           dwe_q;
  logic [6:0]     daddr_q;
  logic [15:0]    di_q;
  logic           rsp_valid_q;
  logic [1:0]     rsp_error_q;
  logic [15:0]    rsp_rdata_q;
  logic           mmcm_rst_q;
  logic           locked_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      old_q       <= '0;
      last_q      <= 1'b0;
      rst_held_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 2'd0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 2'd0;
      rsp_rdata_q <= '0;
      mmcm_rst_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sync1_q     <= i_mmcm_locked;
      sync2_q     <= sync1_q;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= cnt_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            addr_q     <= i_req_addr;
            mask_q     <= i_req_mask;
            data_q     <= i_req_data;
            last_q     <= i_req_last;
            old_q      <= '0;
            err_q      <= 2'd0;
            mmcm_rst_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_RST_ON;
          end
        end
        S_RST_ON: begin
          mmcm_rst_q <= 1'b1;
          rst_held_q <= 1'b1;
          den_q      <= 1'b1;
          daddr_q    <= addr_q;
          cnt_q      <= '0;
          state_q    <= S_RD;
        end
        S_RD: begin
          cnt_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        // DRDY wins over a timeout landing in the same cycle.
        S_RD_WAIT: begin
          if (i_drp_drdy) begin
            old_q   <= i_drp_do;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            di_q    <= (i_drp_do & ~mask_q) | (data_q & mask_q);
            cnt_q   <= '0;
            state_q <= S_WR;
          end else if (cnt_q == DRDY_LIM) begin
            err_q   <= 2'd1;
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        S_WR: begin
          cnt_q   <= '0;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (i_drp_drdy) begin
            cnt_q <= '0;
            if (last_q) begin
              state_q <= S_HOLD;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= err_q;
              rsp_rdata_q <= old_q;
              state_q     <= S_RSP;
            end
          end else if (cnt_q == DRDY_LIM) begin
            err_q   <= 2'd1;
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LIM) begin
            mmcm_rst_q <= 1'b0;
            rst_held_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_LOCK_WAIT;
          end
        end
        S_LOCK_WAIT: begin
          if (sync2_q) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= err_q;
            rsp_rdata_q <= old_q;
            state_q     <= S_RSP;
          end else if (cnt_q == LOCK_LIM) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 2'd2;
            rsp_rdata_q <= old_q;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // sync1_q is the value sync2_q takes this edge, so o_locked tracks the next state.
      locked_q <= sync1_q && !mmcm_rst_q &&
                  ((state_q == S_IDLE && !i_req_valid) || state_q == S_RSP);
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE) || rst_held_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_error = rsp_error_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_drp_den   = den_q;
  assign o_drp_dwe   = dwe_q;
  assign o_drp_daddr = daddr_q;
  assign o_drp_di    = di_q;
  assign o_mmcm_rst  = mmcm_rst_q;
  assign o_locked    = locked_q;

endmodule
